rr_req_arbiter: RTL and testbench



---
 rtl/rr_req_arbiter.sv | 218 +++++++++++++++++++++
 tb/tb_rr_req_arbiter.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rr_req_arbiter.sv
// -----------------------------------------------------------------------------
// rr_req_arbiter
//
// Round-robin arbiter that shares one resource among N requesters. A
// rotating-priority encoder selects the next owner starting at the priority
// pointer. The grant is then held until the owner releases it by pulsing done
// or by dropping its request. Every release moves the pointer to the slot just
// past the previous owner, so a requester that keeps its request high is
// served within N grants.
//
// Optional build macro: ARB_TIMEOUT_EN
//   When this macro is defined, a hold counter limits each grant to MAX_HOLD
//   cycles. A grant that runs to the limit is released by force, and to_pulse
//   is high during the first idle cycle after that release. When the macro is
//   not defined, the counter and the to_pulse port are not built.
//
// Parameters:
//   N         number of requesters (2..16)
//   IDX_W     width of gnt_idx; must equal $clog2(N)
//   MAX_HOLD  maximum grant length in cycles (used only with ARB_TIMEOUT_EN)
//
// Ports:
//   clk       single clock; all state updates on the rising edge
//   rst_n     asynchronous active-low reset
//   req       request vector; bit i high means requester i wants the resource
//   done      release strobe from the current owner; ignored while idle
//   gnt       registered one-hot grant; all zeros when idle
//   gnt_idx   registered binary index of the owner; keeps its value while idle
//   gnt_vld   high while a grant is held (equals |gnt)
//   to_pulse  one-cycle timeout strobe (only with ARB_TIMEOUT_EN)
// -----------------------------------------------------------------------------
module rr_req_arbiter #(
  parameter int N        = 4,
  parameter int IDX_W    = 2,
  parameter int MAX_HOLD = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N-1:0]     req,
  input  logic             done,
  output logic [N-1:0]     gnt,
  output logic [IDX_W-1:0] gnt_idx,
  output logic             gnt_vld
`ifdef ARB_TIMEOUT_EN
  ,
  output logic             to_pulse
`endif
);

  // Stop elaboration when the parameters do not match each other.
  if (N < 2 || N > 16 || IDX_W != $clog2(N) || MAX_HOLD < 1) begin : g_bad_cfg
    $error("rr_req_arbiter: invalid parameter set N=%0d IDX_W=%0d MAX_HOLD=%0d",
           N, IDX_W, MAX_HOLD);
  end

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0]       state_reg, state_next;
  logic [IDX_W-1:0] ptr_reg, ptr_next;
  logic [N-1:0]     gnt_reg, gnt_next;
  logic [IDX_W-1:0] idx_reg, idx_next;
  logic             vld_reg, vld_next;

  // ---------------------------------------------------------------------------
  // Rotating-priority select.
  // The request vector is split into two parts. The upper part holds the
  // requests at or above the pointer, and the second part is the full vector.
  // The lowest set bit of the upper part wins. If the upper part is empty, the
  // search wraps around and the lowest set bit of the full vector wins. This
  // gives the order ptr, ptr+1, ..., N-1, 0, ..., ptr-1 without needing a
  // modulo operation, so it also works when N is not a power of two.
  // ---------------------------------------------------------------------------
  logic [N-1:0]     upper_req;
  logic [IDX_W-1:0] sel_idx;
  logic [N-1:0]     sel_onehot;

  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign upper_req[gi] = req[gi] & (IDX_W'(gi) >= ptr_reg);
    end
  endgenerate

  function automatic logic [IDX_W-1:0] lowest_set(input logic [N-1:0] vec);
    logic [IDX_W-1:0] r;
    r = '0;
    // The scan runs from the top bit down, so the lowest set bit is the last
    // one assigned.
    for (int i = N - 1; i >= 0; i--) begin
      if (vec[i]) r = IDX_W'(i);
    end
    return r;
  endfunction

  assign sel_idx    = (|upper_req) ? lowest_set(upper_req) : lowest_set(req);
  assign sel_onehot = {{(N-1){1'b0}}, 1'b1} << sel_idx;

  // The pointer moves to the slot after the owner and wraps explicitly at N-1.
  logic [IDX_W-1:0] ptr_after_owner;
  assign ptr_after_owner = (idx_reg == IDX_W'(N - 1)) ? '0 : idx_reg + IDX_W'(1);

  // done and a dropped request are the same event. When both happen on the
  // same edge, they cause only one release.
  logic owner_release;
  assign owner_release = done | ~req[idx_reg];

  // ---------------------------------------------------------------------------
  // Optional hold-time limit
  // ---------------------------------------------------------------------------
  logic hold_expired;

`ifdef ARB_TIMEOUT_EN
  // The counter holds (cycles already granted - 1). It reaches MAX_HOLD-1 in
  // the last allowed cycle of the grant, and the following edge releases the
  // grant by force.
  localparam int HOLD_W = (MAX_HOLD < 2) ? 1 : $clog2(MAX_HOLD);

  logic [HOLD_W-1:0] hold_reg, hold_next;
  logic              to_pulse_reg, to_pulse_next;

  assign hold_expired = (hold_reg == HOLD_W'(MAX_HOLD - 1));
  assign to_pulse     = to_pulse_reg;
`else
  assign hold_expired = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_next = state_reg;
    ptr_next   = ptr_reg;
    gnt_next   = gnt_reg;
    idx_next   = idx_reg;
    vld_next   = vld_reg;
`ifdef ARB_TIMEOUT_EN
    hold_next     = hold_reg;
    to_pulse_next = 1'b0;
`endif

    case (state_reg)
      ST_IDLE: begin
        // done is ignored here. Only req can start a grant.
        if (|req) begin
          gnt_next   = sel_onehot;
          idx_next   = sel_idx;
          vld_next   = 1'b1;
          state_next = ST_BUSY;
`ifdef ARB_TIMEOUT_EN
          hold_next  = '0;
`endif
        end
      end

      ST_BUSY: begin
        // Changes on requests other than the owner's are ignored, so there is
        // no preemption.
        if (owner_release || hold_expired) begin
          gnt_next   = '0;
          vld_next   = 1'b0;
          ptr_next   = ptr_after_owner;
          state_next = ST_IDLE;
`ifdef ARB_TIMEOUT_EN
          // A normal release takes precedence over a timeout on the same edge.
          to_pulse_next = ~owner_release;
`endif
        end else begin
`ifdef ARB_TIMEOUT_EN
          hold_next = hold_reg + HOLD_W'(1);
`endif
        end
      end

      default: begin
        state_next = ST_IDLE;
        gnt_next   = '0;
        vld_next   = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= ST_IDLE;
      ptr_reg   <= '0;
      gnt_reg   <= '0;
      idx_reg   <= '0;
      vld_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      ptr_reg   <= ptr_next;
      gnt_reg   <= gnt_next;
      idx_reg   <= idx_next;
      vld_reg   <= vld_next;
    end
  end

`ifdef ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_reg     <= '0;
      to_pulse_reg <= 1'b0;
    end else begin
      hold_reg     <= hold_next;
      to_pulse_reg <= to_pulse_next;
    end
  end
`endif

  assign gnt     = gnt_reg;
  assign gnt_idx = idx_reg;
  assign gnt_vld = vld_reg;

endmodule

// File: tb/tb_rr_req_arbiter.sv
module tb_rr_req_arbiter;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic       done;
  logic [3:0] gnt;
  logic [1:0] gnt_idx;
  logic       gnt_vld;
`ifdef ARB_TIMEOUT_EN
  logic       to_pulse;
`endif

  int checks;
  int failures;
  int cyc;

  rr_req_arbiter #(
    .N        (4),
    .IDX_W    (2),
    .MAX_HOLD (4)
  ) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .done    (done),
    .gnt     (gnt),
    .gnt_idx (gnt_idx),
    .gnt_vld (gnt_vld)
`ifdef ARB_TIMEOUT_EN
    ,
    .to_pulse(to_pulse)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit past it, then log the
  // transaction. Inputs are driven and outputs are checked at that point.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    $display("cyc %0d req=%b done=%b gnt=%b idx=%0d vld=%b", cyc, req, done, gnt, gnt_idx, gnt_vld);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req   = 4'b0000;
    done  = 1'b0;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt: got %b want %b", gnt, 4'b0000); end
    checks++;
    if (gnt_idx !== 2'd0) begin failures++; $display("FAIL reset_idx: got %0d want %0d", gnt_idx, 0); end
    checks++;
    if (gnt_vld !== 1'b0) begin failures++; $display("FAIL reset_vld: got %b want %b", gnt_vld, 1'b0); end
`ifdef ARB_TIMEOUT_EN
    checks++;
    if (to_pulse !== 1'b0) begin failures++; $display("FAIL reset_to: got %b want %b", to_pulse, 1'b0); end
`endif
    rst_n = 1'b1;
    tick();
    checks++;
    if (gnt_vld !== 1'b0) begin failures++; $display("FAIL idle_no_req: got vld=%b want 0", gnt_vld); end
  endtask

  // ptr=0 on entry, ptr=0 on exit.
  task automatic test_basic_grant();
    req = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100) begin failures++; $display("FAIL basic_gnt: got %b want %b", gnt, 4'b0100); end
    checks++;
    if (gnt_idx !== 2'd2) begin failures++; $display("FAIL basic_idx: got %0d want %0d", gnt_idx, 2); end
    checks++;
    if (gnt_vld !== 1'b1) begin failures++; $display("FAIL basic_vld: got %b want %b", gnt_vld, 1'b1); end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin failures++; $display("FAIL basic_release: got gnt=%b vld=%b want 0000/0", gnt, gnt_vld); end
    checks++;
    if (gnt_idx !== 2'd2) begin failures++; $display("FAIL idle_idx_hold: got %0d want %0d", gnt_idx, 2); end
    req = 4'b1111;
    tick();
    checks++;
    if (gnt !== 4'b1000 || gnt_idx !== 2'd3) begin failures++; $display("FAIL ptr_after_2: got gnt=%b idx=%0d want 1000/3", gnt, gnt_idx); end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt_vld !== 1'b0) begin failures++; $display("FAIL drop_release: got vld=%b want 0", gnt_vld); end
  endtask

  // ptr=0 on entry, ptr=1 on exit.
  task automatic test_rr_order();
    logic [1:0] exp_idx [5];
    logic [3:0] one;
    exp_idx = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      tick();
      one = 4'b0001 << exp_idx[k];
      checks++;
      if (gnt !== one || gnt_idx !== exp_idx[k] || gnt_vld !== 1'b1) begin
        failures++;
        $display("FAIL rr_grant%0d: got gnt=%b idx=%0d vld=%b want %b/%0d/1", k, gnt, gnt_idx, gnt_vld, one, exp_idx[k]);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++;
      if (gnt_vld !== 1'b0 || gnt !== 4'b0000) begin failures++; $display("FAIL rr_gap%0d: got gnt=%b vld=%b want 0000/0", k, gnt, gnt_vld); end
    end
    req = 4'b0000;
    tick();
  endtask

  // ptr=1 on entry, ptr=3 on exit.
  task automatic test_req_drop();
    req = 4'b0010;
    tick();
    checks++;
    if (gnt_idx !== 2'd1 || gnt_vld !== 1'b1) begin failures++; $display("FAIL drop_owner: got idx=%0d vld=%b want 1/1", gnt_idx, gnt_vld); end
    req = 4'b1101;
    tick();
    checks++;
    if (gnt_vld !== 1'b0) begin failures++; $display("FAIL drop_rel: got vld=%b want 0", gnt_vld); end
    tick();
    checks++;
    if (gnt !== 4'b0100 || gnt_idx !== 2'd2) begin failures++; $display("FAIL drop_next: got gnt=%b idx=%0d want 0100/2", gnt, gnt_idx); end
    req = 4'b0000;
    tick();
  endtask

  // ptr=3 on entry, ptr=0 on exit.
  task automatic test_no_preempt();
    req = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0001) begin failures++; $display("FAIL nopre_owner: got %b want %b", gnt, 4'b0001); end
    req = 4'b1001;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if (gnt !== 4'b0001 || gnt_vld !== 1'b1) begin failures++; $display("FAIL nopre_hold%0d: got gnt=%b vld=%b want 0001/1", k, gnt, gnt_vld); end
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (gnt_vld !== 1'b0) begin failures++; $display("FAIL nopre_rel: got vld=%b want 0", gnt_vld); end
    tick();
    checks++;
    if (gnt !== 4'b1000 || gnt_idx !== 2'd3) begin failures++; $display("FAIL nopre_next: got gnt=%b idx=%0d want 1000/3", gnt, gnt_idx); end
    req = 4'b0000;
    tick();
  endtask

  // ptr=0 on entry; the grant to 2 would leave ptr=3 without the reset.
  task automatic test_async_reset();
    req = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100) begin failures++; $display("FAIL ar_pre: got %b want %b", gnt, 4'b0100); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (gnt !== 4'b0000 || gnt_vld !== 1'b0) begin failures++; $display("FAIL ar_immediate: got gnt=%b vld=%b want 0000/0", gnt, gnt_vld); end
    tick();
    rst_n = 1'b1;
    req   = 4'b1010;
    tick();
    checks++;
    if (gnt !== 4'b0010 || gnt_idx !== 2'd1) begin failures++; $display("FAIL ar_ptr0: got gnt=%b idx=%0d want 0010/1", gnt, gnt_idx); end
  endtask

  // Owner 1 is held on entry; ptr=1 on exit.
  task automatic test_done_corner();
    req  = 4'b0000;
    done = 1'b1;
    tick();
    checks++;
    if (gnt_vld !== 1'b0) begin failures++; $display("FAIL both_release: got vld=%b want 0", gnt_vld); end
    tick();
    checks++;
    if (gnt_vld !== 1'b0 || gnt !== 4'b0000) begin failures++; $display("FAIL done_idle: got gnt=%b vld=%b want 0000/0", gnt, gnt_vld); end
    // done is still high while idle and must not block the grant (ptr=2).
    req = 4'b0001;
    tick();
    checks++;
    if (gnt !== 4'b0001 || gnt_vld !== 1'b1) begin failures++; $display("FAIL done_idle_grant: got gnt=%b vld=%b want 0001/1", gnt, gnt_vld); end
    tick();
    checks++;
    if (gnt_vld !== 1'b0) begin failures++; $display("FAIL done_busy_rel: got vld=%b want 0", gnt_vld); end
    done = 1'b0;
    req  = 4'b0000;
    tick();
  endtask

`ifdef ARB_TIMEOUT_EN
  // ptr=1 on entry.
  task automatic test_timeout();
    req = 4'b0100;
    for (int k = 0; k < 4; k++) begin
      tick();
      checks++;
      if (gnt !== 4'b0100 || gnt_vld !== 1'b1 || to_pulse !== 1'b0) begin
        failures++;
        $display("FAIL to_hold%0d: got gnt=%b vld=%b to=%b want 0100/1/0", k, gnt, gnt_vld, to_pulse);
      end
    end
    req = 4'b1100;
    tick();
    checks++;
    if (gnt_vld !== 1'b0 || to_pulse !== 1'b1) begin failures++; $display("FAIL to_fire: got vld=%b to=%b want 0/1", gnt_vld, to_pulse); end
    tick();
    checks++;
    if (gnt !== 4'b1000 || to_pulse !== 1'b0) begin failures++; $display("FAIL to_next: got gnt=%b to=%b want 1000/0", gnt, to_pulse); end
    req = 4'b0000;
    tick();
  endtask
`endif

  initial begin
    checks   = 0;
    failures = 0;
    cyc      = 0;
    rst_n    = 1'b0;
    req      = 4'b0000;
    done     = 1'b0;
    test_reset();
    test_basic_grant();
    test_rr_order();
    test_req_drop();
    test_no_preempt();
    test_async_reset();
    test_done_corner();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
